// File: rtl/uart_msg_pkg.sv
// uart_msg_pkg: shared types and default constants for the UART message sequencer.
package uart_msg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT_RDY,
    S_WAIT_ACK,
    S_END,
    S_GAP,
    S_CKSUM
  } seq_state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_MSG_LEN    = 16;
  localparam int DEF_GAP_CYCLES = 38_399;

endpackage

// File: rtl/uart_msg_sequencer_gap_counter.sv
// uart_msg_sequencer_gap_counter: up-counter with synchronous clear and enable.
// It raises a terminal-count flag so the sequencer can time the idle gap
// between repeated messages.
module uart_msg_sequencer_gap_counter
  import uart_msg_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TERMINAL = DEF_GAP_CYCLES - 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [WIDTH-1:0] count;

  // Count enabled cycles; clear wins so every gap starts from zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/uart_msg_sequencer.sv
// uart_msg_sequencer: streams a fixed-length message from an external
// synchronous ROM (1-cycle read latency) into a UART transmitter, one word per
// TxEmpty/XMitGo handshake. Supports one-shot or periodic (REPEAT) operation
// with a programmable inter-message gap and Start/Stop/Busy/Done control.
// Optional feature macro: TX_CHECKSUM_EN appends an XOR checksum word to
// every message; when undefined, exactly MSG_LEN words are sent.
module uart_msg_sequencer
  import uart_msg_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BASE_ADDR  = 0,
  parameter int MSG_LEN    = DEF_MSG_LEN,
  parameter int REPEAT     = 0,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              TxEmpty,
  input  logic [DATA_W-1:0] RomData,
  output logic [ADDR_W-1:0] RomAddr,
  output logic [DATA_W-1:0] TxData,
  output logic              XMitGo,
  output logic              Busy,
  output logic              Done
);

  localparam int                IDX_W     = $clog2(MSG_LEN + 1);
  localparam int                GAP_W     = $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MSG_LEN - 1);
  localparam logic              REPEAT_EN = (REPEAT != 0);

  seq_state_t       state, next_state;
  logic [IDX_W-1:0] idx;
  logic             stop_latched;
  logic             gap_tc;

  // Control strobes decoded by the next-state logic.
  logic start_msg;   // rewind idx/address for a fresh message
  logic load_word;   // capture ROM word into TxData
  logic advance;     // step to the next ROM word

`ifdef TX_CHECKSUM_EN
  logic [DATA_W-1:0] cksum_acc;
  logic              cksum_sent;
  logic              load_cksum;
`endif

  uart_msg_sequencer_gap_counter #(
    .WIDTH    (GAP_W),
    .TERMINAL (GAP_CYCLES - 1)
  ) u_gap_counter (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (state == S_END),
    .enable (state == S_GAP),
    .tc     (gap_tc)
  );

  // State register; any illegal encoding is steered back to IDLE by the decoder.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    start_msg  = 1'b0;
    load_word  = 1'b0;
    advance    = 1'b0;
`ifdef TX_CHECKSUM_EN
    load_cksum = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (Start) begin
          next_state = S_FETCH;
          start_msg  = 1'b1;
        end
      end
      S_FETCH:    next_state = S_LOAD;
      S_LOAD: begin
        next_state = S_WAIT_RDY;
        load_word  = 1'b1;
      end
      S_WAIT_RDY: begin
        if (TxEmpty) next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // The transmitter took the word once TxEmpty falls.
        if (!TxEmpty) begin
`ifdef TX_CHECKSUM_EN
          if (cksum_sent) begin
            next_state = S_END;
          end else if (idx == LAST_IDX) begin
            next_state = S_CKSUM;
          end else begin
            next_state = S_FETCH;
            advance    = 1'b1;
          end
`else
          if (idx == LAST_IDX) begin
            next_state = S_END;
          end else begin
            next_state = S_FETCH;
            advance    = 1'b1;
          end
`endif
        end
      end
      S_END: begin
        // A Stop arriving in the END cycle itself counts as latched.
        if (!REPEAT_EN || stop_latched || Stop) next_state = S_IDLE;
        else                                    next_state = S_GAP;
      end
      S_GAP: begin
        if (Stop) begin
          next_state = S_IDLE;
        end else if (gap_tc) begin
          next_state = S_FETCH;
          start_msg  = 1'b1;
        end
      end
`ifdef TX_CHECKSUM_EN
      S_CKSUM: begin
        next_state = S_WAIT_RDY;
        load_cksum = 1'b1;
      end
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // Registered outputs, word index and ROM address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RomAddr      <= BASE;
      TxData       <= '0;
      XMitGo       <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      idx          <= '0;
      stop_latched <= 1'b0;
    end else begin
      // Single strobe per word: WAIT_RDY is left on the same edge.
      XMitGo <= (state == S_WAIT_RDY) && TxEmpty;
      Busy   <= (next_state != S_IDLE);
      Done   <= (next_state == S_END);

      if (start_msg) begin
        idx     <= '0;
        RomAddr <= BASE;
      end else if (advance) begin
        idx     <= idx + IDX_W'(1);
        RomAddr <= RomAddr + ADDR_W'(1);
      end

`ifdef TX_CHECKSUM_EN
      if (load_word)       TxData <= RomData;
      else if (load_cksum) TxData <= cksum_acc;
`else
      if (load_word) TxData <= RomData;
`endif

      // Stop is remembered until the sequencer is back in IDLE.
      if (next_state == S_IDLE) stop_latched <= 1'b0;
      else if (Stop)            stop_latched <= 1'b1;
    end
  end

`ifdef TX_CHECKSUM_EN
  // XOR checksum over the ROM words of the current message.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cksum_acc  <= '0;
      cksum_sent <= 1'b0;
    end else if (start_msg) begin
      cksum_acc  <= '0;
      cksum_sent <= 1'b0;
    end else begin
      if (load_word)  cksum_acc  <= cksum_acc ^ RomData;
      if (load_cksum) cksum_sent <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// tb_uart_msg_sequencer: directed bench for uart_msg_sequencer. Two instances
// share clock and reset: u_once (one-shot, BASE_ADDR 0) and u_rep (periodic,
// BASE_ADDR 254 so the message wraps past the top of the ROM).
module tb_uart_msg_sequencer;

  localparam int MSG_LEN = 4;
  localparam int GAP     = 20;
`ifdef TX_CHECKSUM_EN
  localparam int NW = MSG_LEN + 1;
`else
  localparam int NW = MSG_LEN;
`endif

  logic       clk = 1'b0;
  logic       Reset;
  logic       start0, start1, stop0, stop1, txe0, txe1;
  logic [7:0] romaddr0, romaddr1, romdata0, romdata1, txdata0, txdata1;
  logic       xmit0, xmit1, busy0, busy1, done0, done1;
  logic [7:0] rom0 [256];
  logic [7:0] rom1 [256];

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] w0[$], w1[$];
  int         xt0[$], xt1[$], dt0[$], dt1[$];

  always #5 clk = ~clk;

  uart_msg_sequencer #(
    .DATA_W(8), .ADDR_W(8), .BASE_ADDR(0), .MSG_LEN(MSG_LEN), .REPEAT(0), .GAP_CYCLES(GAP)
  ) u_once (
    .Clk(clk), .Reset(Reset), .Start(start0), .Stop(stop0), .TxEmpty(txe0),
    .RomData(romdata0), .RomAddr(romaddr0), .TxData(txdata0),
    .XMitGo(xmit0), .Busy(busy0), .Done(done0)
  );

  uart_msg_sequencer #(
    .DATA_W(8), .ADDR_W(8), .BASE_ADDR(254), .MSG_LEN(MSG_LEN), .REPEAT(1), .GAP_CYCLES(GAP)
  ) u_rep (
    .Clk(clk), .Reset(Reset), .Start(start1), .Stop(stop1), .TxEmpty(txe1),
    .RomData(romdata1), .RomAddr(romaddr1), .TxData(txdata1),
    .XMitGo(xmit1), .Busy(busy1), .Done(done1)
  );

  // Synchronous ROMs with one cycle of read latency, plus an edge counter.
  always @(posedge clk) begin
    romdata0 <= rom0[romaddr0];
    romdata1 <= rom1[romaddr1];
    cyc      <= cyc + 1;
  end

  // Monitors: record every strobed word and Done pulse with its cycle number.
  always @(negedge clk) begin
    if (xmit0) begin
      w0.push_back(txdata0);
      xt0.push_back(cyc);
    end
    if (done0) dt0.push_back(cyc);
    if (xmit1) begin
      w1.push_back(txdata1);
      xt1.push_back(cyc);
    end
    if (done1) dt1.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_txe(input int u, input logic v);
    if (u == 0) txe0 = v;
    else        txe1 = v;
  endtask

  // One-cycle Start pulse; t returns the edge at which Start is sampled.
  task automatic pulse_start(input int u, output int t);
    if (u == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_xmit(input int u, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((u == 0) ? xmit0 : xmit1) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  // Transmitter model: wait for a strobe, drop TxEmpty after 'hold' cycles,
  // keep it low for 'low' cycles, then report ready again.
  task automatic serve(input int u, input int hold, input int low);
    wait_xmit(u, "xmit_seen");
    repeat (hold) @(negedge clk);
    set_txe(u, 1'b0);
    repeat (low) @(negedge clk);
    set_txe(u, 1'b1);
  endtask

  task automatic check_msg(input int u, input int base, input string tag,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    logic [7:0] exp [5];
    logic [7:0] act;
    exp[0] = a; exp[1] = b; exp[2] = c; exp[3] = d;
    exp[4] = a ^ b ^ c ^ d;
    for (int i = 0; i < NW; i++) begin
      act = (u == 0) ? w0[base + i] : w1[base + i];
      check($sformatf("%s_word%0d", tag, i), act, exp[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, bw, bd;

    Reset  = 1'b1;
    start0 = 1'b1; start1 = 1'b1;
    stop0  = 1'b0; stop1  = 1'b0;
    txe0   = 1'b1; txe1   = 1'b1;
    rom0[0] = "A"; rom0[1] = "B"; rom0[2] = "C"; rom0[3] = "D";
    rom1[254] = "W"; rom1[255] = "X"; rom1[0] = "Y"; rom1[1] = "Z";

    // Reset held three cycles with Start and TxEmpty high: nothing moves.
    repeat (3) begin
      @(negedge clk);
      check("rst_xmit0", xmit0, 0);
      check("rst_busy0", busy0, 0);
      check("rst_addr0", romaddr0, 0);
      check("rst_addr1", romaddr1, 254);
      check("rst_xmit1", xmit1, 0);
    end
    check("rst_txdata0", txdata0, 0);
    check("rst_done0", done0, 0);
    start0 = 1'b0; start1 = 1'b0;
    Reset  = 1'b0;
    @(negedge clk);
    check("idle_busy0", busy0, 0);

    // One-shot "ABCD" with the 1-then-10 cycle transmitter.
    bw = w0.size(); bd = dt0.size();
    pulse_start(0, t);
    check("busy_on", busy0, 1);
    repeat (NW) serve(0, 1, 10);
    repeat (3) @(negedge clk);
    check("start_latency", xt0[bw] + 1 - t, 4);
    check_msg(0, bw, "abcd", "A", "B", "C", "D");
    check("abcd_done_cnt", dt0.size() - bd, 1);
    check("abcd_done_after_last", dt0[bd] > xt0[bw + NW - 1], 1);
    check("abcd_busy_off", busy0, 0);
    repeat (30) @(negedge clk);
    check("abcd_no_resend", w0.size() - bw, NW);

    // Stall: TxEmpty stays high after the strobe; Start while Busy is ignored.
    bw = w0.size(); bd = dt0.size();
    pulse_start(0, t);
    wait_xmit(0, "stall_first");
    start0 = 1'b1;
    repeat (8) @(negedge clk);
    check("stall_single", w0.size() - bw, 1);
    check("stall_busy", busy0, 1);
    start0 = 1'b0;
    txe0   = 1'b0;
    @(negedge clk);
    txe0 = 1'b1;
    repeat (NW - 1) serve(0, 1, 2);
    repeat (3) @(negedge clk);
    check("stall_words", w0.size() - bw, NW);
    check_msg(0, bw, "stall", "A", "B", "C", "D");
    check("stall_done_cnt", dt0.size() - bd, 1);

    // Reset right after the second strobe abandons the message.
    bw = w0.size(); bd = dt0.size();
    pulse_start(0, t);
    serve(0, 1, 2);
    wait_xmit(0, "rst_mid_second");
    Reset = 1'b1;
    @(negedge clk);
    check("rst_mid_xmit", xmit0, 0);
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_addr", romaddr0, 0);
    Reset = 1'b0;
    txe0  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_quiet", w0.size() - bw, 2);
    check("rst_mid_no_done", dt0.size() - bd, 0);
    bw = w0.size();
    pulse_start(0, t);
    repeat (NW) serve(0, 1, 2);
    repeat (3) @(negedge clk);
    check_msg(0, bw, "restart", "A", "B", "C", "D");
    check("restart_done_cnt", dt0.size() - bd, 1);

    // Checksum pattern: XOR of 1,2,4,8 is 0x0F.
    rom0[0] = 8'h01; rom0[1] = 8'h02; rom0[2] = 8'h04; rom0[3] = 8'h08;
    bw = w0.size(); bd = dt0.size();
    pulse_start(0, t);
    repeat (MSG_LEN) serve(0, 1, 3);
`ifdef TX_CHECKSUM_EN
    wait_xmit(0, "cksum_strobe");
    check("cksum_no_early_done", dt0.size() - bd, 0);
    @(negedge clk);
    txe0 = 1'b0;
    repeat (3) @(negedge clk);
    txe0 = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check_msg(0, bw, "pattern", 8'h01, 8'h02, 8'h04, 8'h08);
    check("pattern_done_cnt", dt0.size() - bd, 1);
    check("pattern_busy_off", busy0, 0);

    // Periodic mode: two messages, Stop raised during the second.
    bw = w1.size(); bd = dt1.size();
    pulse_start(1, t);
    repeat (NW) serve(1, 1, 2);
    serve(1, 1, 2);
    stop1 = 1'b1;
    repeat (NW - 1) serve(1, 1, 2);
    repeat (3) @(negedge clk);
    check("rep_done_cnt", dt1.size() - bd, 2);
    check("rep_gap_latency", xt1[bw + NW] - dt1[bd], GAP + 4);
    check_msg(1, bw, "rep_m1", "W", "X", "Y", "Z");
    check_msg(1, bw + NW, "rep_m2", "W", "X", "Y", "Z");
    check("rep_busy_off", busy1, 0);
    stop1 = 1'b0;
    repeat (40) @(negedge clk);
    check("rep_no_third", w1.size() - bw, 2 * NW);

    // Stop during the gap returns to IDLE immediately.
    bw = w1.size(); bd = dt1.size();
    pulse_start(1, t);
    repeat (NW) serve(1, 1, 2);
    repeat (5) @(negedge clk);
    check("gap_busy_before", busy1, 1);
    stop1 = 1'b1;
    @(negedge clk);
    check("gap_stop_busy", busy1, 0);
    stop1 = 1'b0;
    repeat (40) @(negedge clk);
    check("gap_stop_words", w1.size() - bw, NW);
    check("gap_stop_done_cnt", dt1.size() - bd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
